// File: rtl/decode_stage_pipelined.sv
// ============================================================================
// Module      : decode_stage_pipelined
// Description : MIPS-subset decode stage: register file with write bypass,
//               control decode, load-use hazard detection, ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_pipelined #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           instruction,
    input  logic                  ex_hold,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  hazard_stall,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_rs_data,
    output logic [DATA_W-1:0]     out_rt_data,
    output logic [DATA_W-1:0]     out_imm,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic                  out_alu_src,
    output logic                  out_branch_eq,
    output logic                  out_branch_ne,
    output logic                  out_jump,
    output logic                  out_illegal,
    output logic [2:0]            out_alu_op
);

    localparam int c_NREGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_SPEC2 = 6'h1C;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_J     = 6'h02;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;
    localparam logic [5:0] c_FN_MUL = 6'h02;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_SLT = 3'd4;
    localparam logic [2:0] c_ALU_MUL = 3'd5;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic                  branch_eq;
        logic                  branch_ne;
        logic                  jump;
        logic                  illegal;
        logic [2:0]            alu_op;
    } idex_t;

    logic [DATA_W-1:0]     r_regs [c_NREGS];
    idex_t                 r_idex;
    idex_t                 w_dec;

    logic [5:0]            w_op;
    logic [5:0]            w_funct;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0]     w_imm;
    logic [DATA_W-1:0]     w_rs_data;
    logic [DATA_W-1:0]     w_rt_data;
    logic                  w_reads_rt;
    logic                  w_r_known;
    logic [2:0]            w_r_alu;
    logic                  w_load_use;

    assign w_op    = instruction[31:26];
    assign w_funct = instruction[5:0];
    assign w_rs    = REG_ADDR_W'(instruction[25:21]);
    assign w_rt    = REG_ADDR_W'(instruction[20:16]);
    assign w_rd    = REG_ADDR_W'(instruction[15:11]);
    assign w_imm   = DATA_W'($signed(instruction[15:0]));

    // Register 0 is never written, so reset alone keeps it at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // A matching nonzero index implies a nonzero wb_addr, so r0 never bypasses.
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (w_rs != '0) begin
            w_rs_data = (wb_en && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
        end
        if (w_rt != '0) begin
            w_rt_data = (wb_en && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];
        end
    end

    always_comb begin
        w_r_known = 1'b1;
        w_r_alu   = c_ALU_ADD;
        case (w_funct)
            c_FN_ADD: w_r_alu = c_ALU_ADD;
            c_FN_SUB: w_r_alu = c_ALU_SUB;
            c_FN_AND: w_r_alu = c_ALU_AND;
            c_FN_OR:  w_r_alu = c_ALU_OR;
            c_FN_SLT: w_r_alu = c_ALU_SLT;
            default:  w_r_known = 1'b0;
        endcase
    end

    always_comb begin
        w_dec         = '0;
        w_reads_rt    = 1'b0;
        w_dec.valid   = 1'b1;
        w_dec.rs_data = w_rs_data;
        w_dec.rt_data = w_rt_data;
        w_dec.imm     = w_imm;
        w_dec.rs      = w_rs;
        w_dec.rt      = w_rt;
        case (w_op)
            c_OP_RTYPE: begin
                if (w_r_known) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.dest      = w_rd;
                    w_dec.alu_op    = w_r_alu;
                    w_reads_rt      = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            c_OP_SPEC2: begin
                if (w_funct == c_FN_MUL) begin
                    w_dec.reg_write = 1'b1;
                    w_dec.dest      = w_rd;
                    w_dec.alu_op    = c_ALU_MUL;
                    w_reads_rt      = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            c_OP_ADDI: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.dest      = w_rt;
            end
            c_OP_LW: begin
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.dest       = w_rt;
            end
            c_OP_SW: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_reads_rt      = 1'b1;
            end
            c_OP_BEQ: begin
                w_dec.branch_eq = 1'b1;
                w_dec.alu_op    = c_ALU_SUB;
                w_reads_rt      = 1'b1;
            end
            c_OP_BNE: begin
                w_dec.branch_ne = 1'b1;
                w_dec.alu_op    = c_ALU_SUB;
                w_reads_rt      = 1'b1;
            end
            c_OP_J: begin
                w_dec.jump = 1'b1;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    assign w_load_use = in_valid && r_idex.valid && r_idex.mem_read &&
                        (r_idex.dest != '0) &&
                        ((r_idex.dest == w_rs) ||
                         ((r_idex.dest == w_rt) && w_reads_rt));

    // IF must also hold while EX backpressures, since ID/EX cannot accept.
    assign hazard_stall = w_load_use || ex_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex <= '0;
        end else if (flush) begin
            r_idex <= '0;
        end else if (ex_hold) begin
            r_idex <= r_idex;
        end else if (w_load_use) begin
            r_idex <= '0;
        end else if (in_valid) begin
            r_idex <= w_dec;
        end else begin
            r_idex <= '0;
        end
    end

    assign out_valid      = r_idex.valid;
    assign out_rs_data    = r_idex.rs_data;
    assign out_rt_data    = r_idex.rt_data;
    assign out_imm        = r_idex.imm;
    assign out_rs         = r_idex.rs;
    assign out_rt         = r_idex.rt;
    assign out_dest       = r_idex.dest;
    assign out_reg_write  = r_idex.reg_write;
    assign out_mem_read   = r_idex.mem_read;
    assign out_mem_write  = r_idex.mem_write;
    assign out_mem_to_reg = r_idex.mem_to_reg;
    assign out_alu_src    = r_idex.alu_src;
    assign out_branch_eq  = r_idex.branch_eq;
    assign out_branch_ne  = r_idex.branch_ne;
    assign out_jump       = r_idex.jump;
    assign out_illegal    = r_idex.illegal;
    assign out_alu_op     = r_idex.alu_op;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
// ============================================================================
// Module      : tb_decode_stage_pipelined
// Description : Scoreboard bench for decode_stage_pipelined, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_pipelined;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic        ex_hold;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hazard_stall;
    logic        out_valid;
    logic [31:0] out_rs_data, out_rt_data, out_imm;
    logic [4:0]  out_rs, out_rt, out_dest;
    logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
    logic        out_alu_src, out_branch_eq, out_branch_ne, out_jump, out_illegal;
    logic [2:0]  out_alu_op;

    typedef struct packed {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [8:0]  ctrl;
        logic [2:0]  op;
    } obs_t;

    obs_t got;
    obs_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   bubbles = 0;
    bit   last_load = 1'b0;

    decode_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
        .ex_hold(ex_hold), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .out_valid(out_valid),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_alu_src(out_alu_src), .out_branch_eq(out_branch_eq),
        .out_branch_ne(out_branch_ne), .out_jump(out_jump),
        .out_illegal(out_illegal), .out_alu_op(out_alu_op)
    );

    // ctrl order: reg_write, mem_read, mem_write, mem_to_reg, alu_src, beq, bne, jump, illegal
    assign got = {out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_dest,
                  out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                  out_alu_src, out_branch_eq, out_branch_ne, out_jump, out_illegal,
                  out_alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) last_load <= !rst && !ex_hold;

    always @(negedge clk) begin
        if (last_load && !out_valid) bubbles++;
        if (last_load && out_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_unexpected: got %h with no expected entry", got);
            end else begin
                obs_t e;
                e = sb_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL scoreboard: got rs_d=%h rt_d=%h imm=%h rs=%0d rt=%0d dest=%0d ctrl=%h op=%0d, need rs_d=%h rt_d=%h imm=%h rs=%0d rt=%0d dest=%0d ctrl=%h op=%0d",
                             got.rs_data, got.rt_data, got.imm, got.rs, got.rt, got.dest, got.ctrl, got.op,
                             e.rs_data, e.rt_data, e.imm, e.rs, e.rt, e.dest, e.ctrl, e.op);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] actual, input logic [127:0] need);
        total++;
        if (actual !== need) begin
            bad++;
            $display("FAIL %s: got %0h need %0h", name, actual, need);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                        input logic [8:0] ctrl, input logic [2:0] op);
        sb_q.push_back({a, b, imm, rs, rt, dest, ctrl, op});
    endtask

    // Presents an instruction and holds it while hazard_stall is high, as IF would.
    task automatic issue(input logic [31:0] ins, output int stalls);
        stalls = 0;
        in_valid = 1'b1;
        instruction = ins;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!hazard_stall) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL issue_timeout: instr %h still stalled after 8 cycles", ins);
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    initial begin
        int s;
        int b0;
        obs_t addi_exp;
        rst = 1'b1; in_valid = 1'b0; instruction = '0; ex_hold = 1'b0;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", got, '0);
        chk("reset_valid", out_valid, 0);
        chk("reset_stall", hazard_stall, 0);
        @(posedge clk);
        #1;

        // register file cleared by reset
        push(32'h0, 32'h0, 32'hFFFF8020, 8, 9, 16, 9'h100, 0);
        issue(32'h01098020, s);

        wb(5'd8, 32'd5);
        wb(5'd9, 32'd7);
        push(32'd5, 32'd7, 32'hFFFF8020, 8, 9, 16, 9'h100, 0);
        issue(32'h01098020, s);

        push(32'h0, 32'h0, 32'h0000001A, 10, 17, 17, 9'h110, 0);
        issue(32'h2151001A, s);
        push(32'h0, 32'h0, 32'hFFFFFFFF, 10, 17, 17, 9'h110, 0);
        issue(32'h2151FFFF, s);

        // load-use on rs
        push(32'h0, 32'h0, 32'h0, 16, 20, 20, 9'h1B0, 0);
        issue(32'h8E140000, s);
        b0 = bubbles;
        push(32'h0, 32'd7, 32'hFFFFA820, 20, 9, 21, 9'h100, 0);
        issue(32'h0289A820, s);
        chk("loaduse_rs_stall_cycles", s, 1);
        chk("loaduse_bubbles", bubbles - b0, 1);

        // same-cycle write bypass
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
        push(32'd5, 32'hDEADBEEF, 32'hFFFF8020, 8, 9, 16, 9'h100, 0);
        issue(32'h01098020, s);
        wb_en = 1'b0;

        // r0 ignores writes, both committed and bypassed
        wb(5'd0, 32'h00001234);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h00005678;
        push(32'h0, 32'hDEADBEEF, 32'hFFFF8020, 0, 9, 16, 9'h100, 0);
        issue(32'h00098020, s);
        wb_en = 1'b0;

        // flush beats ex_hold
        flush = 1'b1; ex_hold = 1'b1; in_valid = 1'b1; instruction = 32'h01098020;
        @(posedge clk);
        #1;
        flush = 1'b0; ex_hold = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_hold_valid", out_valid, 0);
        chk("flush_hold_outputs", got, '0);
        @(posedge clk);
        #1;

        // ex_hold freezes ID/EX for several cycles
        addi_exp = {32'h0, 32'h0, 32'h0000001A, 5'd10, 5'd17, 5'd17, 9'h110, 3'd0};
        push(32'h0, 32'h0, 32'h0000001A, 10, 17, 17, 9'h110, 0);
        issue(32'h2151001A, s);
        ex_hold = 1'b1; in_valid = 1'b1; instruction = 32'h01098022;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_outputs", got, addi_exp);
            chk("hold_valid", out_valid, 1);
            chk("hold_stall", hazard_stall, 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("hold_outputs_last", got, addi_exp);
        @(posedge clk);
        #1;
        ex_hold = 1'b0; in_valid = 1'b0;

        // illegal opcode and funct
        push(32'h0, 32'h0, 32'h0, 0, 0, 0, 9'h001, 0);
        issue(32'hFC000000, s);
        push(32'd5, 32'hDEADBEEF, 32'hFFFF8021, 8, 9, 0, 9'h001, 0);
        issue(32'h01098021, s);

        // remaining decode set
        push(32'd5, 32'hDEADBEEF, 32'hFFFF8022, 8, 9, 16, 9'h100, 1);
        issue(32'h01098022, s);
        push(32'd5, 32'hDEADBEEF, 32'hFFFF8024, 8, 9, 16, 9'h100, 2);
        issue(32'h01098024, s);
        push(32'd5, 32'hDEADBEEF, 32'hFFFF8025, 8, 9, 16, 9'h100, 3);
        issue(32'h01098025, s);
        push(32'd5, 32'hDEADBEEF, 32'hFFFF802A, 8, 9, 16, 9'h100, 4);
        issue(32'h0109802A, s);
        push(32'd5, 32'hDEADBEEF, 32'hFFFF8002, 8, 9, 16, 9'h100, 5);
        issue(32'h71098002, s);
        push(32'd5, 32'hDEADBEEF, 32'h00000004, 8, 9, 0, 9'h050, 0);
        issue(32'hAD090004, s);
        push(32'd5, 32'hDEADBEEF, 32'h00000003, 8, 9, 0, 9'h008, 1);
        issue(32'h11090003, s);
        push(32'd5, 32'hDEADBEEF, 32'hFFFFFFFE, 8, 9, 0, 9'h004, 1);
        issue(32'h1509FFFE, s);
        push(32'h0, 32'h0, 32'h00000010, 0, 0, 0, 9'h002, 0);
        issue(32'h08000010, s);

        // lw then addi with matching rt: addi does not read rt, no stall
        push(32'h0, 32'h0, 32'h0, 16, 20, 20, 9'h1B0, 0);
        issue(32'h8E140000, s);
        push(32'h0, 32'h0, 32'h00000001, 10, 20, 20, 9'h110, 0);
        issue(32'h21540001, s);
        chk("loaduse_addi_no_stall", s, 0);

        // lw then beq reading rt: stall
        push(32'h0, 32'h0, 32'h0, 16, 20, 20, 9'h1B0, 0);
        issue(32'h8E140000, s);
        push(32'd5, 32'h0, 32'h00000002, 8, 20, 0, 9'h008, 1);
        issue(32'h11140002, s);
        chk("loaduse_rt_stall_cycles", s, 1);

        // reset asserted during a stall
        push(32'h0, 32'h0, 32'h0, 16, 20, 20, 9'h1B0, 0);
        issue(32'h8E140000, s);
        in_valid = 1'b1; instruction = 32'h0289A820;
        @(negedge clk);
        chk("pre_reset_stall", hazard_stall, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", hazard_stall, 0);
        chk("post_reset_valid", out_valid, 0);
        chk("post_reset_outputs", got, '0);
        push(32'h0, 32'h0, 32'hFFFFA820, 20, 9, 21, 9'h100, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
